dmem_req_stage: RTL and testbench

// - EX/MEM boundary stage: registers the EX result bundle and issues data-memory requests on AXI4-Lite AR, AW and W.
// - Loads and stores leave via AR or AW+W; write data is byte-lane replicated and strobed.
// - Misaligned accesses become exceptions. Non-memory instructions pass through unchanged.
// - Feeds MEM_stage, which consumes the R/B responses and completes the access.

---
 rtl/dmem_req_stage_pkg.sv | 63 ++++++
 rtl/dmem_req_stage_store_align.sv | 41 ++++
 rtl/dmem_req_stage.sv | 187 ++++++++++++++++++
 tb/tb_dmem_req_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_req_stage_pkg.sv
// Shared types for the EX/MEM data-memory request stage.
//   wb_src_t        writeback source select carried in the bundle
//   mem_op_t        load/store size and signedness
//   req_state_t     request FSM states
//   exmem_bundle_t  EX result bundle; kill marks a flushed access that is
//                   forwarded only so MEM can absorb its bus response
package dmem_req_stage_pkg;

   typedef enum logic [1:0] {
      SEL_ALU = 2'd0,
      SEL_MEM = 2'd1,
      SEL_PC4 = 2'd2,
      SEL_CSR = 2'd3
   } wb_src_t;

   typedef enum logic [2:0] {
      MEM_LB  = 3'd0,
      MEM_LH  = 3'd1,
      MEM_LW  = 3'd2,
      MEM_LBU = 3'd3,
      MEM_LHU = 3'd4,
      MEM_SB  = 3'd5,
      MEM_SH  = 3'd6,
      MEM_SW  = 3'd7
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } req_state_t;

   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] im;
      logic [4:0]  rd;
      logic        rd_wena;
      logic [11:0] csr;
      logic        csr_wena;
      wb_src_t     wb_src;
      mem_op_t     mem_op;
      logic        jump;
      logic        trap;
      logic        exc_pend;
      logic [3:0]  exc_cause;
      logic        kill;
   } exmem_bundle_t;

   // log2 of the access size in bytes
   function automatic logic [1:0] mem_size_log2(input mem_op_t op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: return 2'd0;
         MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
         default:                 return 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/dmem_req_stage_store_align.sv
// Byte-lane alignment for data-memory accesses (purely combinational).
//   mem_op     in   access size/type
//   addr_lsb   in   address bits [1:0]
//   wdata_raw  in   store data, unaligned in the LSBs
//   wstrb      out  byte strobes for the addressed lanes
//   wdata      out  store data replicated across all lanes
//   misaligned out  access crosses its natural alignment
module dmem_req_stage_store_align
   import dmem_req_stage_pkg::*;
(
   input  mem_op_t     mem_op,
   input  logic [1:0]  addr_lsb,
   input  logic [31:0] wdata_raw,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        misaligned
);

   always_comb begin
      wstrb      = 4'hF;
      wdata      = wdata_raw;
      misaligned = 1'b0;
      case (mem_size_log2(mem_op))
         2'd0: begin
            wstrb = 4'b0001 << addr_lsb;
            wdata = {4{wdata_raw[7:0]}};
         end
         2'd1: begin
            wstrb      = 4'b0011 << addr_lsb;
            wdata      = {2{wdata_raw[15:0]}};
            misaligned = addr_lsb[0];
         end
         default: begin
            wstrb      = 4'hF;
            wdata      = wdata_raw;
            misaligned = |addr_lsb;
         end
      endcase
   end

endmodule

// File: rtl/dmem_req_stage.sv
// EX/MEM boundary stage: registers the EX bundle and issues data-memory
// requests on AXI4-Lite AR / AW / W. Misaligned accesses are turned into
// exceptions; non-memory bundles pass through with one cycle of latency.
//   clk, reset_n            clock, async active-low reset
//   flush                   kill younger instructions
//   valid_in / ready_out    EX-side handshake
//   valid_out / ready_in    MEM-side handshake
//   bundle_EX, mem_addr_EX, mem_wdata_EX   EX results
//   bundle_REQ              registered bundle (with kill bit) to MEM
//   dmem_axi_aw*, w*, ar*   AXI4-Lite request channels
//
// state | meaning
// IDLE  | accepting; may hold a passthrough/exception bundle in valid_out
// ISSUE | bus request(s) outstanding; bundle waits for all handshakes
// HOLD  | handshakes done; bundle offered to MEM until ready_in
// DRAIN | flushed mid-issue; finish handshakes, forward bundle with kill=1
module dmem_req_stage
   import dmem_req_stage_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          valid_in,
   output logic          ready_out,
   output logic          valid_out,
   input  logic          ready_in,
   input  exmem_bundle_t bundle_EX,
   input  logic [31:0]   mem_addr_EX,
   input  logic [31:0]   mem_wdata_EX,
   output exmem_bundle_t bundle_REQ,
   output logic [31:0]   dmem_axi_awaddr,
   output logic [2:0]    dmem_axi_awprot,
   output logic          dmem_axi_awvalid,
   input  logic          dmem_axi_awready,
   output logic [31:0]   dmem_axi_wdata,
   output logic [3:0]    dmem_axi_wstrb,
   output logic          dmem_axi_wvalid,
   input  logic          dmem_axi_wready,
   output logic [31:0]   dmem_axi_araddr,
   output logic [2:0]    dmem_axi_arprot,
   output logic          dmem_axi_arvalid,
   input  logic          dmem_axi_arready
);

   req_state_t    state, state_nxt;
   exmem_bundle_t bundle_q, bundle_acc;
   logic          valid_q;
   logic          arvalid_q, awvalid_q, wvalid_q;
   logic [31:0]   araddr_q, awaddr_q, wdata_q;
   logic [3:0]    wstrb_q;

   logic          is_mem, is_load, misaligned;
   logic [3:0]    strb_al;
   logic [31:0]   wdata_al;
   logic          flush_drop, accept, bus_go, out_hs, bus_done;
   logic          ar_hs, aw_hs, w_hs;

   dmem_req_stage_store_align u_align (
      .mem_op     (bundle_EX.mem_op),
      .addr_lsb   (mem_addr_EX[1:0]),
      .wdata_raw  (mem_wdata_EX),
      .wstrb      (strb_al),
      .wdata      (wdata_al),
      .misaligned (misaligned)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus_go) state_nxt = ISSUE;
         ISSUE:   if (flush) state_nxt = DRAIN;
                  else if (bus_done) state_nxt = HOLD;
         HOLD:    if (flush || out_hs) state_nxt = IDLE;
         DRAIN:   if (out_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs and handshake qualifiers
   always_comb begin
      is_mem     = (bundle_EX.wb_src == SEL_MEM) && !bundle_EX.exc_pend;
      is_load    = bundle_EX.rd_wena;
      // a killed bundle in DRAIN must still reach MEM, so flush only masks IDLE/HOLD
      flush_drop = flush && ((state == IDLE) || (state == HOLD));
      valid_out  = valid_q && !flush_drop;
      ready_out  = (state == IDLE) && (!valid_out || ready_in);
      accept     = valid_in && ready_out && !flush;
      bus_go     = accept && is_mem && !misaligned;
      out_hs     = valid_out && ready_in;
      ar_hs      = arvalid_q && dmem_axi_arready;
      aw_hs      = awvalid_q && dmem_axi_awready;
      w_hs       = wvalid_q && dmem_axi_wready;
      // true when every channel still asserted completes on this edge
      bus_done   = (!arvalid_q || dmem_axi_arready) &&
                   (!awvalid_q || dmem_axi_awready) &&
                   (!wvalid_q  || dmem_axi_wready);

      bundle_acc      = bundle_EX;
      bundle_acc.kill = 1'b0;
      if (is_mem && misaligned) begin
         bundle_acc.exc_pend  = 1'b1;
         bundle_acc.exc_cause = is_load ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
         bundle_acc.rd_wena   = 1'b0;
         bundle_acc.csr_wena  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         araddr_q  <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         if (ar_hs) arvalid_q <= 1'b0;
         if (aw_hs) awvalid_q <= 1'b0;
         if (w_hs)  wvalid_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (flush) begin
                  valid_q  <= 1'b0;
                  bundle_q <= '0;
               end else begin
                  if (out_hs) valid_q <= 1'b0;
                  if (accept) begin
                     bundle_q <= bundle_acc;
                     valid_q  <= !bus_go;
                     if (bus_go) begin
                        if (is_load) begin
                           arvalid_q <= 1'b1;
                           araddr_q  <= mem_addr_EX;
                        end else begin
                           awvalid_q <= 1'b1;
                           wvalid_q  <= 1'b1;
                           awaddr_q  <= mem_addr_EX;
                           wdata_q   <= wdata_al;
                           wstrb_q   <= strb_al;
                        end
                     end
                  end
               end
            end
            ISSUE: begin
               if (flush)    bundle_q.kill <= 1'b1;
               if (bus_done) valid_q <= 1'b1;
            end
            HOLD: begin
               if (flush) begin
                  valid_q  <= 1'b0;
                  bundle_q <= '0;
               end else if (out_hs) begin
                  valid_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_hs)        valid_q <= 1'b0;
               else if (bus_done) valid_q <= 1'b1;
            end
            default: valid_q <= 1'b0;
         endcase
      end
   end

   assign bundle_REQ       = bundle_q;
   assign dmem_axi_awaddr  = awaddr_q;
   assign dmem_axi_awprot  = 3'b000;
   assign dmem_axi_awvalid = awvalid_q;
   assign dmem_axi_wdata   = wdata_q;
   assign dmem_axi_wstrb   = wstrb_q;
   assign dmem_axi_wvalid  = wvalid_q;
   assign dmem_axi_araddr  = araddr_q;
   assign dmem_axi_arprot  = 3'b000;
   assign dmem_axi_arvalid = arvalid_q;

endmodule

// File: tb/tb_dmem_req_stage.sv
module tb_dmem_req_stage;
   import dmem_req_stage_pkg::*;

   logic          clk = 1'b0;
   logic          reset_n, flush, valid_in, ready_in;
   logic          ready_out, valid_out;
   exmem_bundle_t bundle_EX, bundle_REQ;
   logic [31:0]   mem_addr_EX, mem_wdata_EX;
   logic [31:0]   awaddr, wdata, araddr;
   logic [2:0]    awprot, arprot;
   logic [3:0]    wstrb;
   logic          awvalid, awready, wvalid, wready, arvalid, arready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   dmem_req_stage dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .valid_in(valid_in), .ready_out(ready_out),
      .valid_out(valid_out), .ready_in(ready_in),
      .bundle_EX(bundle_EX), .mem_addr_EX(mem_addr_EX), .mem_wdata_EX(mem_wdata_EX),
      .bundle_REQ(bundle_REQ),
      .dmem_axi_awaddr(awaddr), .dmem_axi_awprot(awprot),
      .dmem_axi_awvalid(awvalid), .dmem_axi_awready(awready),
      .dmem_axi_wdata(wdata), .dmem_axi_wstrb(wstrb),
      .dmem_axi_wvalid(wvalid), .dmem_axi_wready(wready),
      .dmem_axi_araddr(araddr), .dmem_axi_arprot(arprot),
      .dmem_axi_arvalid(arvalid), .dmem_axi_arready(arready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      exmem_bundle_t b;
      int            pending;   // bus handshakes still owed by this bundle
      bit            has_bus;
   } exp_entry_t;

   exp_entry_t  outq[$];
   logic [31:0] arq[$];
   logic [31:0] awq[$];
   logic [35:0] wq[$];

   function automatic int op_bytes(input mem_op_t op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: return 1;
         MEM_LH, MEM_LHU, MEM_SH: return 2;
         default:                 return 4;
      endcase
   endfunction

   function automatic logic [3:0] exp_strb(input int n, input int off);
      logic [3:0] s;
      for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + n);
      return s;
   endfunction

   function automatic logic [31:0] exp_wdata(input int n, input logic [31:0] d);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
      return w;
   endfunction

   task automatic dec_pending();
      for (int i = 0; i < outq.size(); i++) begin
         if (outq[i].pending > 0) begin
            outq[i].pending = outq[i].pending - 1;
            break;
         end
      end
   endtask

   always @(negedge clk) begin : compare
      exp_entry_t e;
      logic exp_vo, exp_ro, mem, misal;
      int n, off;
      if (!reset_n) begin
         outq.delete(); arq.delete(); awq.delete(); wq.delete();
      end else begin
         exp_vo = (outq.size() > 0) && (outq[0].pending == 0) && (!flush || outq[0].b.kill);
         if (outq.size() == 0)      exp_ro = 1'b1;
         else if (outq[0].has_bus)  exp_ro = 1'b0;
         else                       exp_ro = ready_in || flush;
         chk("valid_out", 128'(valid_out), 128'(exp_vo));
         chk("ready_out", 128'(ready_out), 128'(exp_ro));
         chk("arvalid",   128'(arvalid),   128'(arq.size() > 0));
         chk("awvalid",   128'(awvalid),   128'(awq.size() > 0));
         chk("wvalid",    128'(wvalid),    128'(wq.size() > 0));
         if (arvalid && arq.size() > 0) chk("araddr", 128'(araddr), 128'(arq[0]));
         if (awvalid && awq.size() > 0) chk("awaddr", 128'(awaddr), 128'(awq[0]));
         if (wvalid && wq.size() > 0)   chk("w_payload", 128'({wdata, wstrb}), 128'(wq[0]));
         if (arvalid || awvalid) chk("prot", 128'({awprot, arprot}), 128'(0));

         if (valid_out && ready_in && outq.size() > 0) begin
            chk("bundle_out", 128'(bundle_REQ), 128'(outq[0].b));
            void'(outq.pop_front());
         end

         // flush: bundles still owed a bus response survive as killed, the rest vanish
         if (flush) begin
            for (int i = outq.size() - 1; i >= 0; i--) begin
               e = outq[i];
               if (e.pending > 0) begin
                  e.b.kill = 1'b1;
                  outq[i] = e;
               end else if (!e.b.kill) begin
                  outq.delete(i);
               end
            end
         end

         if (arvalid && arready && arq.size() > 0) begin void'(arq.pop_front()); dec_pending(); end
         if (awvalid && awready && awq.size() > 0) begin void'(awq.pop_front()); dec_pending(); end
         if (wvalid && wready && wq.size() > 0)    begin void'(wq.pop_front());  dec_pending(); end

         if (valid_in && ready_out && !flush) begin
            n     = op_bytes(bundle_EX.mem_op);
            off   = int'(mem_addr_EX[1:0]);
            mem   = (bundle_EX.wb_src == SEL_MEM) && !bundle_EX.exc_pend;
            misal = (off % n) != 0;
            e.b = bundle_EX;
            e.b.kill = 1'b0;
            e.pending = 0;
            e.has_bus = 1'b0;
            if (mem && misal) begin
               e.b.exc_pend  = 1'b1;
               e.b.exc_cause = bundle_EX.rd_wena ? 4'd4 : 4'd6;
               e.b.rd_wena   = 1'b0;
               e.b.csr_wena  = 1'b0;
            end else if (mem) begin
               e.has_bus = 1'b1;
               if (bundle_EX.rd_wena) begin
                  arq.push_back(mem_addr_EX);
                  e.pending = 1;
               end else begin
                  awq.push_back(mem_addr_EX);
                  wq.push_back({exp_wdata(n, mem_wdata_EX), exp_strb(n, off)});
                  e.pending = 2;
               end
            end
            outq.push_back(e);
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic exmem_bundle_t mk(input logic [31:0] pc, input wb_src_t ws,
                                        input mem_op_t op, input logic rdw, input logic exc);
      exmem_bundle_t b;
      b = '0;
      b.pc = pc; b.ir = pc ^ 32'h1234_5678; b.im = pc + 32'd4;
      b.rd = pc[6:2]; b.rd_wena = rdw; b.csr = 12'h300; b.csr_wena = 1'b1;
      b.wb_src = ws; b.mem_op = op; b.exc_pend = exc;
      b.exc_cause = exc ? 4'd2 : 4'd0;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input exmem_bundle_t b, input logic [31:0] a, input logic [31:0] d);
      int n;
      bundle_EX = b; mem_addr_EX = a; mem_wdata_EX = d; valid_in = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(ready_out && !flush) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 128'(1), 128'(0));
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      @(negedge clk);
      while (!(!valid_out && !arvalid && !awvalid && !wvalid && ready_out) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("quiet_timeout", 128'(1), 128'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int c0;
      reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      bundle_EX = '0; mem_addr_EX = '0; mem_wdata_EX = '0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_out", 128'(valid_out), 128'(0));
      chk("rst_valids", 128'({arvalid, awvalid, wvalid}), 128'(0));
      chk("rst_bundle", 128'(bundle_REQ), 128'(0));
      chk("rst_addr", 128'({araddr, awaddr}), 128'(0));
      chk("rst_wdata", 128'({wdata, wstrb}), 128'(0));
      reset_n = 1'b1;
      tick();

      // LW 0x100 with arready high: one-cycle AR, bundle on the following cycle
      arready = 1'b1;
      send(mk(32'h1000, SEL_MEM, MEM_LW, 1'b1, 1'b0), 32'h100, 32'h0);
      @(negedge clk);
      chk("lw_arvalid", 128'(arvalid), 128'(1));
      chk("lw_araddr", 128'(araddr), 128'(32'h100));
      chk("lw_ready_out_low", 128'(ready_out), 128'(0));
      chk("lw_no_early_valid", 128'(valid_out), 128'(0));
      @(negedge clk);
      chk("lw_arvalid_drop", 128'(arvalid), 128'(0));
      chk("lw_valid_out", 128'(valid_out), 128'(1));
      wait_quiet();

      // SB 0x203 data A5, W accepted three cycles after AW
      arready = 1'b0; awready = 1'b1; wready = 1'b0;
      send(mk(32'h1004, SEL_MEM, MEM_SB, 1'b0, 1'b0), 32'h203, 32'h1234_56A5);
      @(negedge clk);
      chk("sb_wstrb", 128'(wstrb), 128'(4'b1000));
      chk("sb_wdata", 128'(wdata), 128'(32'hA5A5_A5A5));
      chk("sb_awaddr", 128'(awaddr), 128'(32'h203));
      @(negedge clk);
      chk("sb_aw_first", 128'({awvalid, wvalid}), 128'(2'b01));
      @(posedge clk); #1;
      @(posedge clk); #1;
      wready = 1'b1;
      wait_quiet();
      wready = 1'b0;

      // SH 0x102: upper half lanes
      awready = 1'b1; wready = 1'b1;
      send(mk(32'h1008, SEL_MEM, MEM_SH, 1'b0, 1'b0), 32'h102, 32'h1234_BEEF);
      @(negedge clk);
      chk("sh_wstrb", 128'(wstrb), 128'(4'b1100));
      chk("sh_wdata", 128'(wdata), 128'(32'hBEEF_BEEF));
      wait_quiet();

      // SW 0x104 with W completing before AW
      awready = 1'b0; wready = 1'b1;
      send(mk(32'h100C, SEL_MEM, MEM_SW, 1'b0, 1'b0), 32'h104, 32'hDEAD_BEEF);
      repeat (3) @(posedge clk);
      #1;
      awready = 1'b1;
      wait_quiet();
      awready = 1'b0; wready = 1'b0;

      // LH 0x101: misaligned load becomes an exception, no bus access
      arready = 1'b1;
      send(mk(32'h1010, SEL_MEM, MEM_LH, 1'b1, 1'b0), 32'h101, 32'h0);
      @(negedge clk);
      chk("lh_no_ar", 128'(arvalid), 128'(0));
      chk("lh_exc", 128'({bundle_REQ.exc_pend, bundle_REQ.exc_cause, bundle_REQ.rd_wena}),
          128'({1'b1, 4'd4, 1'b0}));
      wait_quiet();

      // SW 0x106 misaligned store, LBU 0x0FF, exception-pending LW at odd address
      send(mk(32'h1014, SEL_MEM, MEM_SW, 1'b0, 1'b0), 32'h106, 32'h0);
      @(negedge clk);
      chk("sw_mis_cause", 128'({bundle_REQ.exc_cause, awvalid}), 128'({4'd6, 1'b0}));
      wait_quiet();
      send(mk(32'h1018, SEL_MEM, MEM_LBU, 1'b1, 1'b0), 32'h0FF, 32'h0);
      wait_quiet();
      send(mk(32'h101C, SEL_MEM, MEM_LW, 1'b1, 1'b1), 32'h003, 32'h0);
      wait_quiet();

      // passthrough with ready_in toggling
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(mk(32'h2000 + 32'(i * 4), SEL_ALU, MEM_LB, 1'b1, 1'b0), 32'(i), 32'h0);
         end
         begin
            for (int i = 0; i < 20; i++) begin
               tick();
               ready_in = ~ready_in;
            end
         end
      join
      ready_in = 1'b1;
      wait_quiet();

      // one-cycle latency, then back-to-back accepts
      send(mk(32'h3000, SEL_CSR, MEM_LB, 1'b1, 1'b0), 32'h0, 32'h0);
      @(negedge clk);
      chk("pass_latency", 128'({valid_out, bundle_REQ.pc}), 128'({1'b1, 32'h3000}));
      @(posedge clk); #1;
      c0 = cyc;
      for (int i = 0; i < 4; i++)
         send(mk(32'h3100 + 32'(i * 4), SEL_PC4, MEM_LB, 1'b1, 1'b0), 32'h0, 32'h0);
      chk("b2b_cycles", 128'(cyc - c0), 128'(4));
      wait_quiet();

      // flush while AR is stalled: AR held, bundle forwarded killed
      arready = 1'b0;
      send(mk(32'h4000, SEL_MEM, MEM_LW, 1'b1, 1'b0), 32'h180, 32'h0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_ar_held", 128'({arvalid, araddr}), 128'({1'b1, 32'h180}));
      @(posedge clk); #1;
      arready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("flush_kill_fwd", 128'({valid_out, bundle_REQ.kill}), 128'(2'b11));
      wait_quiet();

      // flush in HOLD drops the bundle
      ready_in = 1'b0;
      send(mk(32'h4100, SEL_MEM, MEM_LW, 1'b1, 1'b0), 32'h1C0, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", 128'(valid_out), 128'(1));
      @(posedge clk); #1;
      flush = 1'b1;
      #1;
      chk("hold_flush_mask", 128'(valid_out), 128'(0));
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("hold_flush_clear", 128'({valid_out, ready_out, bundle_REQ}), 128'({1'b0, 1'b1, 128'd0}));
      ready_in = 1'b1;
      tick();

      // flush together with accept: accept ignored
      bundle_EX = mk(32'h4200, SEL_ALU, MEM_LB, 1'b1, 1'b0);
      valid_in = 1'b1; flush = 1'b1;
      tick();
      valid_in = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_accept", 128'(valid_out), 128'(0));
      @(posedge clk); #1;

      // reset mid-ISSUE
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      send(mk(32'h5000, SEL_MEM, MEM_SW, 1'b0, 1'b0), 32'h200, 32'h1111_2222);
      @(negedge clk);
      chk("pre_rst_aw", 128'({awvalid, wvalid}), 128'(2'b11));
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valids", 128'({awvalid, wvalid, arvalid, valid_out}), 128'(0));
      tick(); tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 128'({ready_out, awvalid, wvalid}), 128'(3'b100));
      @(posedge clk); #1;
      arready = 1'b1;
      send(mk(32'h5004, SEL_MEM, MEM_LH, 1'b1, 1'b0), 32'h202, 32'h0);
      wait_quiet();

      chk("model_drained", 128'(outq.size() + arq.size() + awq.size() + wq.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
